// File: rtl/reorder_buffer.sv
// reorder_buffer: circular ROB that allocates ids in order, captures three writebacks,
// serves two operand lookups and retires in order. Optional same-cycle lookup bypass: ROB_LOOKUP_BYPASS_EN.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 3
`endif
`ifndef ARCH_REG_INDEX_SIZE
`define ARCH_REG_INDEX_SIZE 5
`endif

module reorder_buffer #(
  parameter int WORD_SIZE       = `WORD_SIZE,
  parameter int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH,
  parameter int REG_W           = `ARCH_REG_INDEX_SIZE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_req,
  input  logic [REG_W-1:0]           alloc_rd,
  input  logic                       alloc_is_store,
  output logic [ROB_ENTRY_WIDTH-1:0] assigned_rob_id,
  output logic                       full,
  input  logic                       alu_wb_en,
  input  logic [ROB_ENTRY_WIDTH-1:0] alu_wb_rob_id,
  input  logic [WORD_SIZE-1:0]       alu_wb_data,
  input  logic                       mem_wb_en,
  input  logic [ROB_ENTRY_WIDTH-1:0] mem_wb_rob_id,
  input  logic [WORD_SIZE-1:0]       mem_wb_data,
  input  logic                       mul_wb_en,
  input  logic [ROB_ENTRY_WIDTH-1:0] mul_wb_rob_id,
  input  logic [WORD_SIZE-1:0]       mul_wb_data,
  input  logic [ROB_ENTRY_WIDTH-1:0] rs1_rob_entry,
  input  logic [ROB_ENTRY_WIDTH-1:0] rs2_rob_entry,
  output logic [WORD_SIZE-1:0]       rob_s1_data,
  output logic [WORD_SIZE-1:0]       rob_s2_data,
  output logic                       rob_s1_valid,
  output logic                       rob_s2_valid,
  output logic                       commit,
  output logic [REG_W-1:0]           commit_rd,
  output logic [ROB_ENTRY_WIDTH-1:0] commit_rob_id,
  output logic [WORD_SIZE-1:0]       din,
  output logic                       store_commit,
  input  logic                       flush,
  input  logic [ROB_ENTRY_WIDTH-1:0] flush_rob_id
);

  localparam int PW = ROB_ENTRY_WIDTH;
  localparam int N  = 2 ** PW;
  localparam logic [PW-1:0] PTR_ONE  = 1;
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(N);

  logic [N-1:0]         busy_q, done_q, is_store_q;
  logic [REG_W-1:0]     rd_q   [N];
  logic [WORD_SIZE-1:0] data_q [N];
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d, flush_off;
  logic [PW:0]          count_q, count_d;
  logic                 alloc_accept, retire;
  logic [N-1:0]         squash, alu_hit, mem_hit, mul_hit;

  assign full         = (count_q == CNT_FULL);
  assign alloc_accept = alloc_req && !full && !flush;
  assign retire       = busy_q[head_q] && done_q[head_q];
  assign flush_off    = flush_rob_id - head_q;

  assign assigned_rob_id = tail_q;
  assign commit          = retire && !is_store_q[head_q];
  assign store_commit    = retire && is_store_q[head_q];
  assign commit_rd       = rd_q[head_q];
  assign commit_rob_id   = head_q;
  assign din             = data_q[head_q];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_entry
      localparam logic [PW-1:0] IDX = PW'(gi);
      logic [PW-1:0] age;
      // Age relative to head; anything older than the flush point survives.
      assign age         = IDX - head_q;
      assign squash[gi]  = flush && (age > flush_off);
      assign alu_hit[gi] = alu_wb_en && (alu_wb_rob_id == IDX) && busy_q[gi] && !squash[gi];
      assign mem_hit[gi] = mem_wb_en && (mem_wb_rob_id == IDX) && busy_q[gi] && !squash[gi];
      assign mul_hit[gi] = mul_wb_en && (mul_wb_rob_id == IDX) && busy_q[gi] && !squash[gi];
    end
  endgenerate

  always_comb begin
    head_d  = retire ? head_q + PTR_ONE : head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      tail_d  = flush_rob_id + PTR_ONE;
      count_d = {1'b0, flush_off} + CNT_ONE;
    end else if (alloc_accept) begin
      tail_d  = tail_q + PTR_ONE;
      count_d = count_q + CNT_ONE;
    end
    if (retire) count_d = count_d - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      busy_q     <= '0;
      done_q     <= '0;
      is_store_q <= '0;
      for (int i = 0; i < N; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < N; i++) begin
        if (alloc_accept && tail_q == PW'(i)) begin
          busy_q[i]     <= 1'b1;
          done_q[i]     <= 1'b0;
          is_store_q[i] <= alloc_is_store;
          rd_q[i]       <= alloc_rd;
        end else if (squash[i] || (retire && head_q == PW'(i))) begin
          busy_q[i] <= 1'b0;
          done_q[i] <= 1'b0;
        end else if (alu_hit[i]) begin
          done_q[i] <= 1'b1;
          data_q[i] <= alu_wb_data;
        end else if (mem_hit[i]) begin
          done_q[i] <= 1'b1;
          data_q[i] <= mem_wb_data;
        end else if (mul_hit[i]) begin
          done_q[i] <= 1'b1;
          data_q[i] <= mul_wb_data;
        end
      end
    end
  end

  logic [PW-1:0] src_id [2];
  assign src_id[0] = rs1_rob_entry;
  assign src_id[1] = rs2_rob_entry;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic                 v;
      logic [WORD_SIZE-1:0] d;
      always_comb begin
        v = busy_q[src_id[gi]] && done_q[src_id[gi]];
        d = data_q[src_id[gi]];
`ifdef ROB_LOOKUP_BYPASS_EN
        // Later assignments win, so ALU is checked last to take priority.
        if (busy_q[src_id[gi]]) begin
          if (mul_wb_en && mul_wb_rob_id == src_id[gi]) begin
            v = 1'b1;
            d = mul_wb_data;
          end
          if (mem_wb_en && mem_wb_rob_id == src_id[gi]) begin
            v = 1'b1;
            d = mem_wb_data;
          end
          if (alu_wb_en && alu_wb_rob_id == src_id[gi]) begin
            v = 1'b1;
            d = alu_wb_data;
          end
        end
`endif
      end
    end
  endgenerate

  assign rob_s1_valid = g_src[0].v;
  assign rob_s1_data  = g_src[0].d;
  assign rob_s2_valid = g_src[1].v;
  assign rob_s2_data  = g_src[1].d;

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular reorder buffer (ROB) that answers the rename and decode stage.
- Allocates ROB ids in program order and reports full.
- Captures results from the ALU, MEM and MUL writeback ports.
- Serves operand lookups for two sources.
- Retires the oldest completed entry each cycle through the commit interface that drives the register file and rename table.
- Sits between decode, the three execution writebacks and the register file.

Parameters:
- WORD_SIZE, `WORD_SIZE, data width.
- ROB_ENTRY_WIDTH, `ROB_ENTRY_WIDTH, id width. Depth N = 2**ROB_ENTRY_WIDTH.
- REG_W, `ARCH_REG_INDEX_SIZE, architectural register index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- alloc_req  in  1  decode requests an entry (require_rob_entry)
- alloc_rd  in  REG_W  destination register of the allocating instruction
- alloc_is_store  in  1  allocating instruction is a store
- assigned_rob_id  out  ROB_ENTRY_WIDTH  id granted on an accepted alloc (current tail)
- full  out  1  count == N
- alu_wb_en, mem_wb_en, mul_wb_en  in  1 each  writeback strobes
- alu_wb_rob_id, mem_wb_rob_id, mul_wb_rob_id  in  ROB_ENTRY_WIDTH each  writeback targets
- alu_wb_data, mem_wb_data, mul_wb_data  in  WORD_SIZE each  results
- rs1_rob_entry, rs2_rob_entry  in  ROB_ENTRY_WIDTH each  lookup ids
- rob_s1_data, rob_s2_data  out  WORD_SIZE each  entry value
- rob_s1_valid, rob_s2_valid  out  1 each  entry allocated and completed
- commit  out  1  non-store head retiring (RF write enable)
- commit_rd  out  REG_W  head destination register
- commit_rob_id  out  ROB_ENTRY_WIDTH  head id
- din  out  WORD_SIZE  head value
- store_commit  out  1  store head retiring
- flush  in  1  squash entries younger than flush_rob_id
- flush_rob_id  in  ROB_ENTRY_WIDTH  last surviving entry

Behaviour:
State
- Per entry: busy, done, is_store, rd, data.
- head and tail are ROB_ENTRY_WIDTH-bit pointers that wrap mod N.
- count is ROB_ENTRY_WIDTH+1 bits.

Reset
- rst low clears all busy/done, head, tail and count to 0 asynchronously.
- Resulting outputs: full=0, commit=0, store_commit=0, assigned_rob_id=0, rob_s*_valid=0.
- Data outputs reset to 0.
- Reset mid-operation discards all entries.

Allocation
- Accepted when alloc_req && !full && !flush.
- On accept: entry[tail] gets busy=1, done=0, rd, is_store; tail++ at the clock edge.
- assigned_rob_id = tail, combinational and valid in the request cycle.
- full is computed from the registered count. A commit in the same cycle does not admit an alloc when full.

Writeback
- Each enabled port sets done=1 and data for its target if the entry is busy. Writes to non-busy entries are ignored.
- Same-entry conflicts are resolved by priority ALU > MEM > MUL.
- Stores complete through mem_wb_en; data is ignored.

Lookup
- Combinational: rob_sX_valid = busy[id] && done[id]; rob_sX_data = data[id].

Commit
- Combinational from the head entry: retire when busy[head] && done[head].
- commit = retire && !is_store[head]; store_commit = retire && is_store[head].
- At the clock edge on retire: busy[head] cleared, head++.
- One retirement per cycle. Latency from writeback to commit is at least 1 cycle.

count
- count_next = count + alloc_accept - retire.

Flush
- Entries strictly younger than flush_rob_id are cleared (busy=0, done=0).
- tail_next = flush_rob_id + 1.
- count_next = ((flush_rob_id - head) mod N) + 1 - retire.
- Writebacks to squashed entries in the flush cycle are dropped.
- Retire of head in the flush cycle proceeds normally.
- flush_rob_id must name a busy entry; otherwise behaviour is undefined.

Wrap-around
- Pointers wrap from N-1 to 0 with no bubble. Full at count=N with head==tail.

Optional Feature:
Macro: ROB_LOOKUP_BYPASS_EN
- Defined: the lookup ports also see same-cycle writebacks. If any wb_en targets a busy entry matching rsX_rob_entry, rob_sX_valid=1 and rob_sX_data is that port's data, using the same ALU>MEM>MUL priority.
- Undefined: lookup reflects registered state only. The forward unit covers same-cycle values.

Test Plan:
1. Reset then 4 allocs (rd=1..4) → assigned_rob_id 0,1,2,3; count=4; full=0; no commit.
2. N=8: fill 8 entries, then alloc_req → full=1 and no tail change. mul_wb id0 data=0x55 → next cycle commit=1, commit_rd=rd0, din=0x55, commit_rob_id=0; full drops the cycle after.
3. Out-of-order: ALU writeback id2=0xA, then id1=0xB, then id0=0xC → commits in order 0,1,2 on consecutive cycles with values 0xC, 0xB, 0xA.
4. Store at id0 with mem_wb_en → store_commit=1, commit=0. Lookup rs1_rob_entry=1 before writeback gives rob_s1_valid=0; after writeback gives 1 with data.
5. Allocate ids 0..5, flush with flush_rob_id=2 → tail=3, count=3, ids 3..5 lookup valid=0. A writeback to id4 in the same cycle is dropped. The next alloc gets id 3.
6. Wrap: cycle allocate/commit continuously for 20 instructions with N=8 → ids sequence 0..7,0..7,0..3, all committed in order, no gaps.
